// File: rtl/operand_sel_pipe.sv
// Two-stage valid/ready operand selector: picks one of NIN source words or an extended immediate.
// Optional macro OPSEL_UPPER_EN enables ext_mode=10 upper (LUI-style) extension.
`timescale 1ns/1ps
module operand_sel_pipe #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16,
  parameter int NIN   = 4,
  parameter int SELW  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIN*WIDTH-1:0] src,
  input  logic [SELW-1:0]      sel,
  input  logic                 use_imm,
  input  logic [IMM_W-1:0]     imm,
  input  logic [1:0]           ext_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 sel_err,
  output logic [CNT_W-1:0]     xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_e;

  stage_e           s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d, y_q, y_d;
  logic             s1_err_q, s1_err_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire, out_fire, s2_load;
  logic [WIDTH-1:0] ext_w, src_w, opnd_w;
  logic             hit_w;

  // Immediate extension; reserved and (when disabled) upper modes fall back to zero-extend.
  always_comb begin
    ext_w = WIDTH'(imm);
    case (ext_mode)
      2'b01:   ext_w = WIDTH'($signed(imm));
`ifdef OPSEL_UPPER_EN
      2'b10:   ext_w = WIDTH'(imm) << (WIDTH - IMM_W);
`endif
      default: ext_w = WIDTH'(imm);
    endcase
  end

  // Loop-based mux keeps out-of-range selects from indexing past the source bus.
  always_comb begin
    src_w = '0;
    hit_w = 1'b0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (SELW'(k) == sel) begin
        src_w = src[k*WIDTH +: WIDTH];
        hit_w = 1'b1;
      end
    end
  end

  assign opnd_w = use_imm ? ext_w : src_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= EMPTY;
      s2_q      <= EMPTY;
      s1_data_q <= '0;
      s1_err_q  <= 1'b0;
      y_q       <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s1_data_q <= s1_data_d;
      s1_err_q  <= s1_err_d;
      y_q       <= y_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    s1_data_d = s1_data_q;
    s1_err_d  = s1_err_q;
    y_d       = y_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (s2_load) begin
      s2_d  = FULL;
      y_d   = s1_data_q;
      err_d = s1_err_q;
    end else if (out_fire) begin
      s2_d = EMPTY;
    end
    if (in_fire) begin
      s1_d      = FULL;
      s1_data_d = opnd_w;
      s1_err_d  = !use_imm && !hit_w;
    end else if (s2_load) begin
      s1_d = EMPTY;
    end
    if (out_fire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    out_valid = (s2_q == FULL);
    in_ready  = (s1_q == EMPTY) || (s2_q == EMPTY) || out_ready;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    s2_load   = (s1_q == FULL) && ((s2_q == EMPTY) || out_ready);
  end

  assign y        = y_q;
  assign sel_err  = err_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe (NIN=3, CNT_W=4): vector table plus backpressure, wrap and reset sequences.
`timescale 1ns/1ps
module tb_operand_sel_pipe;
  localparam int WIDTH = 32;
  localparam int IMM_W = 16;
  localparam int NIN   = 3;
  localparam int SELW  = 2;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 reset, in_valid, in_ready, use_imm, out_valid, out_ready, sel_err;
  logic [NIN*WIDTH-1:0] src;
  logic [SELW-1:0]      sel;
  logic [IMM_W-1:0]     imm;
  logic [1:0]           ext_mode;
  logic [WIDTH-1:0]     y;
  logic [CNT_W-1:0]     xfer_cnt;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  operand_sel_pipe #(
    .WIDTH(WIDTH), .IMM_W(IMM_W), .NIN(NIN), .SELW(SELW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src(src), .sel(sel), .use_imm(use_imm), .imm(imm), .ext_mode(ext_mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sel_err(sel_err),
    .xfer_cnt(xfer_cnt)
  );

  typedef struct {
    logic        use_imm;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic [1:0]  ext;
    logic [31:0] exp_y;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_cnt  = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = 1'b1;
    use_imm   = v.use_imm;
    sel       = v.sel;
    imm       = v.imm;
    ext_mode  = v.ext;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("vec%0d_latency", idx), 32'(out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
    check($sformatf("vec%0d_y", idx), y, v.exp_y);
    check($sformatf("vec%0d_err", idx), 32'(sel_err), 32'(v.exp_err));
    exp_cnt++;
    @(negedge clk);
    check($sformatf("vec%0d_cnt", idx), 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i, got, done_c, seen;
    logic acc;
    logic [31:0] upper_exp;

`ifdef OPSEL_UPPER_EN
    upper_exp = 32'h80010000;
`else
    upper_exp = 32'h00008001;
`endif
    vecs[0]  = '{1'b0, 2'd2, 16'h0000, 2'd0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 16'h0000, 2'd0, 32'h11111111, 1'b0};
    vecs[2]  = '{1'b0, 2'd1, 16'h0000, 2'd0, 32'h22222222, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 16'h0000, 2'd0, 32'h00000000, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 16'h0000, 2'd0, 32'h11111111, 1'b0};
    vecs[5]  = '{1'b1, 2'd0, 16'h8001, 2'd0, 32'h00008001, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 16'h8001, 2'd1, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 16'h8001, 2'd3, 32'h00008001, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 16'h8001, 2'd2, upper_exp,    1'b0};
    vecs[9]  = '{1'b1, 2'd0, 16'h7FFF, 2'd1, 32'h00007FFF, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 16'h8001, 2'd1, 32'hFFFF8001, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; use_imm = 1'b0;
    sel = '0; imm = '0; ext_mode = '0;
    src = {32'hDEADBEEF, 32'h22222222, 32'h11111111};

    // Reset with an input offered during reset; it must not be accepted.
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_err", 32'(sel_err), 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_accept", 32'(out_valid), 32'd0);

    for (int v = 0; v < 11; v++) run_vec(vecs[v], v);

    // Backpressure: five beats 1..5 with the consumer stalled.
    use_imm = 1'b0; sel = 2'd0; out_ready = 1'b0; i = 1; got = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      src[0 +: WIDTH] = 32'(i);
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) i++;
    end
    @(negedge clk);
    #1;
    check("bp_accepts", 32'(i - 1), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_y", y, 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        check($sformatf("bp_y%0d", got), y, 32'(got + 1));
        got++;
        exp_cnt++;
      end
      in_valid = (i <= 5);
      src[0 +: WIDTH] = 32'(i);
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_got", 32'(got), 32'd5);
    check("bp_cnt_wrap", 32'(xfer_cnt), 32'(exp_cnt));

    // Counter wrap and full throughput: 17 back-to-back transfers from reset.
    do_reset();
    check("wrap_cnt0", 32'(xfer_cnt), 32'd0);
    out_ready = 1'b1; i = 1; got = 0; done_c = -1;
    for (int c = 0; c < 40 && got < 17; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check($sformatf("wrap_y%0d", got), y, 32'(got + 1));
        got++;
        exp_cnt++;
        if (got == 17) done_c = c;
      end
      in_valid = (i <= 17);
      src[0 +: WIDTH] = 32'(i);
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("wrap_tput_cycle", 32'(done_c), 32'd18);
    check("wrap_cnt", 32'(xfer_cnt), 32'd1);

    // Reset with both stages full must discard everything in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      src[0 +: WIDTH] = 32'(100 + c);
    end
    @(negedge clk);
    #1;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    check("mid_full_in_ready", 32'(in_ready), 32'd0);
    src[0 +: WIDTH] = 32'h55;
    do_reset();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    check("mid_rst_y", y, 32'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_leak", 32'(seen), 32'd0);
    check("mid_rst_cnt_after", 32'(xfer_cnt), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised, pipelined operand selector for the datapath: picks one of NIN source words or an extended immediate and delivers it through a two-stage valid/ready pipeline. It generalises the fixed 32-bit/5-bit two-input selectors and the zero-only immediate extender. It adds a configurable input count, sign/zero/upper extension, backpressure, a select-range error flag and a transfer counter. It sits between register-file read and ALU operand input in the multicycle/pipelined datapath.

## Interface
- WIDTH, 32, data word width (≥ IMM_W)
- IMM_W, 16, immediate width
- NIN, 4, number of source words (≥ 2)
- SELW, 2, select width; 2^SELW ≥ NIN
- CNT_W, 16, transfer counter width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept input this cycle
- src  in  NIN*WIDTH  flattened sources; source k = src[k*WIDTH +: WIDTH]
- sel  in  SELW  source index
- use_imm  in  1  1: output extended imm instead of src
- imm  in  IMM_W  immediate
- ext_mode  in  2  00 zero-ext, 01 sign-ext, 10 upper, 11 reserved
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts output
- y  out  WIDTH  selected/extended operand
- sel_err  out  1  beat on y had sel ≥ NIN with use_imm=0
- xfer_cnt  out  CNT_W  count of completed output transfers

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 (on input transfer) registers the operand:
  - use_imm=1: extended imm; sel ignored; err=0.
  - use_imm=0, sel<NIN: src[sel]; err=0.
  - use_imm=0, sel≥NIN: all-zero word; err=1.
- Extension: 00 → {zeros, imm}; 01 → {replicate imm[IMM_W-1], imm}; 10 → see Configuration; 11 → treated as 00.
- Stage 2 holds y/sel_err/out_valid; y and sel_err are stable while out_valid && !out_ready.
- Pipeline states per stage: EMPTY / FULL (s1_v, s2_v).
  - s2 loads from s1 when s1_v && (!s2_v || out_ready).
  - s2 clears when out transfer and s1 empty.
  - in_ready = !s1_v || !s2_v || out_ready (s1 drains same cycle).
- Full throughput: one beat/cycle sustained when out_ready held high.
- xfer_cnt increments by 1 per output transfer; wraps 2^CNT_W-1 → 0.
- Beat order preserved; no beat dropped or duplicated.

## Timing
- Reset (synchronous, sampled at clk edge with reset=1): s1_v=0, s2_v=0, out_valid=0, y=0, sel_err=0, xfer_cnt=0; in_ready=1 the cycle after.
- Reset mid-operation discards all in-flight beats; any input presented in the reset cycle is not accepted.
- Latency: input accepted at edge N → out_valid=1 after edge N+1 (2 registers, visible in cycle N+2 relative to presentation at cycle N).
- Simultaneous in and out transfer with both stages full: s2 takes s1, s1 takes new input, no bubble.
- Both stages full and out_ready=0: in_ready=0; inputs held off.
- in_ready depends combinationally on out_ready (single combinational path, no other).

## Configuration
- Macro OPSEL_UPPER_EN.
- Defined: ext_mode=10 yields {imm, zeros} (imm in top IMM_W bits, LUI form).
- Undefined: ext_mode=10 treated as 00 (zero-extend); no upper-shift logic synthesised.

## Test plan
- Reset then single beat: sel=2, src[2]=0xDEADBEEF, use_imm=0, out_ready=1 → y=0xDEADBEEF, sel_err=0, out_valid 2 cycles after accept, xfer_cnt=1.
- Extension: imm=0x8001 with ext_mode 00/01/11 → y=0x00008001/0xFFFF8001/0x00008001; with OPSEL_UPPER_EN, ext_mode 10 → 0x80010000, without → 0x00008001.
- Backpressure: stream 5 beats with values 1..5 and out_ready=0 → in_ready drops after 2 accepts; releasing out_ready → y=1,2,3,4,5 in order, no loss, xfer_cnt=5.
- Range error (NIN=3, SELW=2): sel=3, use_imm=0 → y=0, sel_err=1; next beat sel=0 → sel_err=0.
- Counter wrap (CNT_W=4): 17 transfers → xfer_cnt=1.
- Reset mid-stream with both stages full → out_valid=0, xfer_cnt=0, no pending beat emerges afterwards.
